bus_arbiter: RTL

Central arbiter for the shared serial bus. Collects `b_req` from up to `NUM_MASTERS` bus masters and issues a one-hot `b_grntd` to exactly one of them. Tracks the wired `b_bus_utilizing` line to detect when a transfer has started and when it has finished. Sits beside the slaves on the bus fabric and is the only agent that drives any grant line.

---
 rtl/bus_arb_pkg.sv | 19 +
 rtl/arb_picker.sv | 35 +++
 rtl/bus_arbiter.sv | 115 +++++++++++
 3 files changed

// File: rtl/bus_arb_pkg.sv
// Shared types and constants for the bus arbiter: FSM state encoding,
// timeout counter width, master-count ceiling and a modular index helper.
package bus_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_GRANT   = 2'd1,
    ST_BUSY    = 2'd2,
    ST_RELEASE = 2'd3
  } arb_state_t;

  localparam int TMO_W       = 8;
  localparam int MAX_MASTERS = 8;

  function automatic int wrap_add(input int base, input int off, input int n);
    return (base + off) % n;
  endfunction

endpackage

// File: rtl/arb_picker.sv
// Combinational winner selection: first requester found scanning upward from
// start, wrapping modulo N. start = 0 gives plain lowest-index-wins priority.
module arb_picker
  import bus_arb_pkg::*;
#(
  parameter int N     = 3,
  parameter int IDX_W = $clog2(N)
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] start,
  output logic [N-1:0]     onehot,
  output logic [IDX_W-1:0] idx,
  output logic             valid
);

  int   pos;
  logic hit;

  // Scan all positions; only the first hit sets valid, later hits are masked.
  always_comb begin
    onehot = '0;
    idx    = '0;
    valid  = 1'b0;
    pos    = 0;
    hit    = 1'b0;
    for (int k = 0; k < MAX_MASTERS; k++) begin
      pos = wrap_add(int'(start), k, N);
      hit = (k < N) && !valid && req[pos[IDX_W-1:0]];
      onehot[pos[IDX_W-1:0]] = onehot[pos[IDX_W-1:0]] | hit;
      idx   = hit ? pos[IDX_W-1:0] : idx;
      valid = valid | hit;
    end
  end

endmodule

// File: rtl/bus_arbiter.sv
// Central shared-bus arbiter: IDLE/GRANT/BUSY/RELEASE FSM with grant timeout.
// Define BUS_ARB_ROUND_ROBIN_EN for round-robin selection; default is fixed priority.
module bus_arbiter
  import bus_arb_pkg::*;
#(
  parameter int NUM_MASTERS   = 3,
  parameter int GRANT_TIMEOUT = 15,
  parameter int IDX_W         = $clog2(NUM_MASTERS)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NUM_MASTERS-1:0] b_req,
  input  logic                   b_bus_utilizing,
  output logic [NUM_MASTERS-1:0] b_grntd,
  output logic [IDX_W-1:0]       arb_owner,
  output logic                   arb_busy,
  output logic                   arb_timeout
);

  arb_state_t             state;
  logic [TMO_W-1:0]       cnt;
  logic [IDX_W-1:0]       start;
  logic [NUM_MASTERS-1:0] pick_onehot;
  logic [IDX_W-1:0]       pick_idx;
  logic                   pick_valid;

`ifdef BUS_ARB_ROUND_ROBIN_EN
  // Holds the index where the next search begins (one past the last owner).
  logic [IDX_W-1:0] ptr;
  assign start = ptr;
`else
  assign start = '0;
`endif

  arb_picker #(
    .N     (NUM_MASTERS),
    .IDX_W (IDX_W)
  ) u_picker (
    .req    (b_req),
    .start  (start),
    .onehot (pick_onehot),
    .idx    (pick_idx),
    .valid  (pick_valid)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= ST_IDLE;
      cnt         <= '0;
      b_grntd     <= '0;
      arb_owner   <= '0;
      arb_busy    <= 1'b0;
      arb_timeout <= 1'b0;
`ifdef BUS_ARB_ROUND_ROBIN_EN
      ptr         <= '0;
`endif
    end else begin
      arb_timeout <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (pick_valid) begin
            b_grntd   <= pick_onehot;
            arb_owner <= pick_idx;
            arb_busy  <= 1'b1;
            cnt       <= TMO_W'(GRANT_TIMEOUT);
            state     <= ST_GRANT;
          end else begin
            b_grntd  <= '0;
            arb_busy <= 1'b0;
          end
        end
        ST_GRANT: begin
          if (b_bus_utilizing == 1'b1) begin
            state <= ST_BUSY;
`ifdef BUS_ARB_ROUND_ROBIN_EN
            ptr <= (arb_owner == IDX_W'(NUM_MASTERS - 1)) ? '0 : arb_owner + IDX_W'(1);
`endif
          end else if (!b_req[arb_owner]) begin
            b_grntd  <= '0;
            arb_busy <= 1'b0;
            state    <= ST_RELEASE;
          end else if (cnt == '0) begin
            b_grntd     <= '0;
            arb_busy    <= 1'b0;
            arb_timeout <= 1'b1;
            state       <= ST_RELEASE;
          end else begin
            cnt <= cnt - TMO_W'(1);
          end
        end
        ST_BUSY: begin
          // Only an explicit 1'b1 counts as busy on the pulled-low wired line.
          if (b_bus_utilizing != 1'b1) begin
            b_grntd  <= '0;
            arb_busy <= 1'b0;
            state    <= ST_RELEASE;
          end else begin
            state <= ST_BUSY;
          end
        end
        ST_RELEASE: begin
          b_grntd  <= '0;
          arb_busy <= 1'b0;
          state    <= ST_IDLE;
        end
        default: begin
          b_grntd  <= '0;
          arb_busy <= 1'b0;
          state    <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
